led_pwm_ctrl: RTL and testbench

Memory-mapped brightness controller for the board LEDs. It sits on the CPU peripheral bus and replaces the fixed 50% LED dimmer. It holds a software-written duty value per LED and generates a glitch-free PWM waveform for each LED. Duty updates are double-buffered and take effect only at a PWM period boundary.

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_pwm_channel.sv | 56 +++++
 rtl/led_pwm_ctrl.sv | 141 ++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM controller: register map, CTRL layout and FSM states.
// Optional LED_FADE_EN build adds the FADE register located at addr_fade(NUM_LEDS).
package led_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL  = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_DUTY0 = 4'd1;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_PENDING_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } led_state_e;

  typedef struct packed {
    logic [DATA_W-3:0] rsvd;
    logic              pending;
    logic              enable;
  } ctrl_reg_t;

  // FADE sits directly after the last DUTY register.
  function automatic logic [ADDR_W-1:0] addr_fade(input int unsigned num_leds);
    return ADDR_W'(num_leds + 1);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: staging/shadow duty registers, shadow update at period wrap and PWM compare.
// With LED_FADE_EN the shadow may step by one per wrap toward staging instead of jumping.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                duty_we,
  input  logic [PWM_BITS:0]   duty_wdata,
`ifdef LED_FADE_EN
  input  logic                fade,
`endif
  input  logic                load,
  input  logic                wrap,
  input  logic                run,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS:0]   staging,
  output logic                pending_c,
  output logic                led
);

  logic [PWM_BITS:0] shadow, shadow_nxt;

  assign pending_c = (staging != shadow);

  // Shadow only changes on enable entry or at a period wrap, using the pre-write staging.
  always_comb begin
    shadow_nxt = shadow;
    if (load) begin
      shadow_nxt = staging;
    end else if (wrap) begin
`ifdef LED_FADE_EN
      if (fade && (shadow < staging))      shadow_nxt = shadow + (PWM_BITS+1)'(1);
      else if (fade && (shadow > staging)) shadow_nxt = shadow - (PWM_BITS+1)'(1);
      else                                 shadow_nxt = staging;
`else
      shadow_nxt = staging;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
      shadow  <= '0;
      led     <= 1'b0;
    end else begin
      if (duty_we) staging <= duty_wdata;
      shadow <= shadow_nxt;
      led    <= run && ({1'b0, pwm_cnt} < shadow);
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED brightness controller: register file, IDLE/RUN FSM and shared PWM timebase.
// Define LED_FADE_EN to add the FADE register and ramped per-LED duty updates.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [NUM_LEDS-1:0] leds_o,
  output logic                period_o
);

  localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DUTY_W = PWM_BITS + 1;

  led_state_e          state, state_nxt;
  logic                load_c;
  logic                run_c;
  logic                ctrl_wr_c;
  logic                tick_c;
  logic                wrap_c;
  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] duty_we_c;
  logic [NUM_LEDS-1:0] pending_c;
  logic [DUTY_W-1:0]   staging [NUM_LEDS];
  logic [DATA_W-1:0]   rd_data_c;
  ctrl_reg_t           ctrl_c;
  logic                unused_wdata;

`ifdef LED_FADE_EN
  logic [NUM_LEDS-1:0] fade_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               fade_q <= '0;
    else if (wr_en_i && (addr_i == addr_fade(NUM_LEDS)))     fade_q <= wdata_i[NUM_LEDS-1:0];
  end
`endif

  assign unused_wdata = ^wdata_i[DATA_W-1:DUTY_W];
  assign run_c        = (state == RUN);
  assign ctrl_wr_c    = wr_en_i && (addr_i == ADDR_CTRL);
  assign tick_c       = run_c && (presc == PS_W'(PRESCALE - 1));
  assign wrap_c       = tick_c && (pwm_cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Enable entry from IDLE also loads every shadow from staging.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    case (state)
      IDLE: if (ctrl_wr_c && wdata_i[CTRL_ENABLE_BIT]) begin
        state_nxt = RUN;
        load_c    = 1'b1;
      end
      RUN: if (ctrl_wr_c && !wdata_i[CTRL_ENABLE_BIT]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timebase is held at zero outside RUN so every enable starts a fresh period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      period_o <= 1'b0;
    end else begin
      period_o <= wrap_c;
      if (!run_c) begin
        presc   <= '0;
        pwm_cnt <= '0;
      end else if (tick_c) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end else begin
        presc <= presc + PS_W'(1);
      end
    end
  end

  always_comb begin
    duty_we_c = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      duty_we_c[i] = wr_en_i && (addr_i == ADDR_W'(int'(ADDR_DUTY0) + i));
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .duty_we    (duty_we_c[g]),
      .duty_wdata (wdata_i[DUTY_W-1:0]),
`ifdef LED_FADE_EN
      .fade       (fade_q[g]),
`endif
      .load       (load_c),
      .wrap       (wrap_c),
      .run        (run_c),
      .pwm_cnt    (pwm_cnt),
      .staging    (staging[g]),
      .pending_c  (pending_c[g]),
      .led        (leds_o[g])
    );
  end

  // Read mux sees pre-write register values, so a same-cycle write is not reflected.
  always_comb begin
    rd_data_c      = '0;
    ctrl_c         = '0;
    ctrl_c.enable  = run_c;
    ctrl_c.pending = |pending_c;
    if (addr_i == ADDR_CTRL) rd_data_c = ctrl_c;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (addr_i == ADDR_W'(int'(ADDR_DUTY0) + i)) rd_data_c = DATA_W'(staging[i]);
    end
`ifdef LED_FADE_EN
    if (addr_i == addr_fade(NUM_LEDS)) rd_data_c = DATA_W'(fade_q);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rdata_o <= '0;
    else if (rd_en_i) rdata_o <= rd_data_c;
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl against a period/duty-level reference model.
// Fade scenario is compiled in only when LED_FADE_EN is defined.
module tb_led_pwm_ctrl;

  localparam int unsigned NUM    = 4;
  localparam int unsigned PB     = 8;
  localparam int unsigned PS     = 1;
  localparam int unsigned PERIOD = 1 << PB;
  localparam int unsigned WIN    = PERIOD * PS;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en_i = 1'b0;
  logic           rd_en_i = 1'b0;
  logic [3:0]     addr_i = '0;
  logic [31:0]    wdata_i = '0;
  logic [31:0]    rdata_o;
  logic [NUM-1:0] leds_o;
  logic           period_o;

  led_pwm_ctrl #(
    .NUM_LEDS (NUM),
    .PWM_BITS (PB),
    .PRESCALE (PS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (wr_en_i),
    .rd_en_i  (rd_en_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .leds_o   (leds_o),
    .period_o (period_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: enable flag, cycles since enable, staging/shadow duty per LED.
  bit             m_run;
  int unsigned    m_n;
  int unsigned    m_stage  [NUM];
  int unsigned    m_shadow [NUM];
  int unsigned    m_fade;
  logic [31:0]    m_rdata;
  logic [NUM-1:0] x_leds;
  logic           x_period;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_n = 0; m_fade = 0; m_rdata = '0; x_leds = '0; x_period = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      m_stage[i] = 0; m_shadow[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    bit pend = 0;
    for (int i = 0; i < NUM; i++) if (m_stage[i] != m_shadow[i]) pend = 1;
    if (a == 0) return {30'd0, pend, m_run};
    if (a >= 1 && a <= NUM) return 32'(m_stage[a-1]);
`ifdef LED_FADE_EN
    if (a == NUM + 1) return 32'(m_fade);
`endif
    return 32'd0;
  endfunction

  // Advance the model by one clock edge using the inputs presented before that edge.
  task automatic model_clock(input bit wr, input bit rd, input logic [3:0] a, input logic [31:0] d);
    int unsigned cnt;
    bit wrap;
    cnt  = m_run ? (m_n / PS) % PERIOD : 0;
    wrap = m_run && (m_n % PS == PS - 1) && (cnt == PERIOD - 1);
    for (int i = 0; i < NUM; i++) x_leds[i] = m_run && (cnt < m_shadow[i]);
    x_period = wrap;
    if (rd) m_rdata = model_read(a);
    if (!m_run && wr && a == 0 && d[0]) begin
      m_shadow = m_stage;
    end else if (wrap) begin
      for (int i = 0; i < NUM; i++) begin
        if (m_fade[i] && m_shadow[i] < m_stage[i])      m_shadow[i]++;
        else if (m_fade[i] && m_shadow[i] > m_stage[i]) m_shadow[i]--;
        else                                            m_shadow[i] = m_stage[i];
      end
    end
    m_n = m_run ? m_n + 1 : 0;
    if (wr) begin
      if (a == 0) m_run = d[0];
      else if (a >= 1 && a <= NUM) m_stage[a-1] = d & ((32'd1 << (PB + 1)) - 1);
`ifdef LED_FADE_EN
      else if (a == NUM + 1) m_fade = d & ((32'd1 << NUM) - 1);
`endif
    end
  endtask

  task automatic step(input bit wr, input bit rd, input logic [3:0] a, input logic [31:0] d);
    wr_en_i = wr; rd_en_i = rd; addr_i = a; wdata_i = d;
    @(posedge clk);
    model_clock(wr, rd, a, d);
    #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    check("leds", 32'(leds_o), 32'(x_leds));
    check("period", 32'(period_o), 32'(x_period));
    check("rdata", rdata_o, m_rdata);
  endtask

  task automatic idle(input int unsigned n);
    for (int k = 0; k < n; k++) step(0, 0, 4'd0, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1, 0, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    step(0, 1, a, 32'd0);
  endtask

  task automatic sync_period();
    int unsigned k = 0;
    do begin
      step(0, 0, 4'd0, 32'd0);
      k++;
    end while (!period_o && k < 2 * WIN + 4);
    if (!period_o) check("period_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_win(input int unsigned n, output int unsigned h0, output int unsigned h1,
                           output int unsigned h2, output int unsigned np);
    h0 = 0; h1 = 0; h2 = 0; np = 0;
    for (int k = 0; k < n; k++) begin
      step(0, 0, 4'd0, 32'd0);
      h0 += 32'(leds_o[0]); h1 += 32'(leds_o[1]); h2 += 32'(leds_o[2]); np += 32'(period_o);
    end
  endtask

  initial begin
    int unsigned h0, h1, h2, np, h_pre, k;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_leds", 32'(leds_o), 32'd0);
    check("rst_period", 32'(period_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 16; a++) rd(4'(a));

    // Fixed duty pattern: 64, off, full on, random.
    wr(4'd1, 32'd64); wr(4'd2, 32'd0); wr(4'd3, 32'd256); wr(4'd4, 32'($urandom_range(0, 256)));
    for (int a = 0; a < 5; a++) rd(4'(a));
    wr(4'd0, 32'd1);
    sync_period();
    count_win(WIN, h0, h1, h2, np);
    check("duty64_on", h0, 64 * PS);
    check("duty0_on", h1, 0);
    check("duty256_on", h2, WIN);
    check("period_count", np, 1);

    // Mid-period update is deferred to the next wrap.
    wr(4'd1, 32'd100);
    sync_period();
    idle(WIN / 2);
    wr(4'd1, 32'd200);
    rd(4'd0);
    check("pending_set", 32'(rdata_o[1]), 32'd1);
    sync_period();
    rd(4'd0);
    check("pending_clr", 32'(rdata_o[1]), 32'd0);
    count_win(WIN, h0, h1, h2, np);
    check("duty200_on", h0, 200 * PS);

    // Write landing on the wrap cycle waits a full period.
    sync_period();
    idle(WIN - 1);
    wr(4'd1, 32'd50);
    check("wrap_write_hit", 32'(period_o), 32'd1);
    rd(4'd0);
    check("wrap_pending", 32'(rdata_o[1]), 32'd1);
    h_pre = 32'(leds_o[0]);
    count_win(WIN - 1, h0, h1, h2, np);
    check("wrap_old_duty", h0 + h_pre, 200 * PS);
    count_win(WIN, h0, h1, h2, np);
    check("wrap_new_duty", h0, 50 * PS);

    // Same-cycle read and write returns the old value.
    wr(4'd1, 32'd77);
    step(1, 1, 4'd1, 32'd99);
    check("rw_same", rdata_o, 32'd77);
    rd(4'd1);

    for (int k2 = 0; k2 < 400; k2++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);
    end

`ifdef LED_FADE_EN
    wr(4'(NUM + 1), 32'd0);
`endif
    // Disable drops LEDs two cycles after the strobe; re-enable restarts the period.
    wr(4'd0, 32'd0); wr(4'd3, 32'd256); wr(4'd0, 32'd1);
    idle(10);
    wr(4'd0, 32'd0);
    check("disable_lag", 32'(leds_o[2]), 32'd1);
    idle(1);
    check("disable_leds", 32'(leds_o), 32'd0);
    wr(4'd0, 32'd1);
    k = 0;
    do begin
      step(0, 0, 4'd0, 32'd0);
      k++;
    end while (!period_o && k < 2 * WIN);
    check("restart_len", k, WIN);

    // Asynchronous reset in the middle of a period.
    wr(4'd1, 32'd128);
    idle(100);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_leds", 32'(leds_o), 32'd0);
    check("async_rst_period", 32'(period_o), 32'd0);
    check("async_rst_rdata", rdata_o, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(WIN + 8);

`ifdef LED_FADE_EN
    wr(4'd1, 32'd10); wr(4'(NUM + 1), 32'd1); wr(4'd0, 32'd1); wr(4'd1, 32'd13);
    for (int f = 1; f <= 3; f++) begin
      sync_period();
      rd(4'd0);
      check("fade_pending", 32'(rdata_o[1]), (f < 3) ? 32'd1 : 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
